// File: rtl/gate_sweep.sv
// gate_sweep: N-input logic gate with a built-in truth-table sequencer.
// Steps vec_out through all 2^N vectors, DWELL cycles each, counting ones.
module gate_sweep #(
    parameter int N     = 3,
    parameter int DWELL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   mode,
    output logic [N-1:0] vec_out,
    output logic         x_out,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_mode;
    logic [N-1:0]  r_vec;
    logic [DW-1:0] r_dwell;
    logic [N:0]    r_ones;

    logic w_last;
    logic w_all_ones;
    logic w_gate;
    logic w_x;

    assign w_last     = (r_dwell == DW'(DWELL - 1));
    assign w_all_ones = &r_vec;

    always_comb begin
        w_gate = 1'b0;
        case (r_mode)
            3'd0:    w_gate = &r_vec;
            3'd1:    w_gate = |r_vec;
            3'd2:    w_gate = ~&r_vec;
            3'd3:    w_gate = ~|r_vec;
            3'd4:    w_gate = ^r_vec;
            3'd5:    w_gate = ~^r_vec;
            default: w_gate = 1'b0;
        endcase
    end

    assign w_x = (r_state == S_RUN) & w_gate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_last && w_all_ones) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Abort wins over the last-dwell count on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= '0;
            r_vec   <= '0;
            r_dwell <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_vec   <= '0;
                        r_dwell <= '0;
                        r_ones  <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_vec   <= '0;
                        r_dwell <= '0;
                    end else if (w_last) begin
                        r_ones  <= r_ones + (N + 1)'(w_x);
                        r_dwell <= '0;
                        r_vec   <= r_vec + 1'b1;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                default: begin
                    r_vec   <= '0;
                    r_dwell <= '0;
                end
            endcase
        end
    end

    assign vec_out    = r_vec;
    assign x_out      = w_x;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign ones_count = r_ones;

endmodule

// File: tb/tb_gate_sweep.sv
// Directed testbench for gate_sweep: main N=3/DWELL=2 instance plus
// N=1/DWELL=1 and N=8/DWELL=1 corner instances.
module tb_gate_sweep;

    logic clk;
    logic rst;

    logic       start_a, abort_a;
    logic [2:0] mode_a;
    logic [2:0] vec_a;
    logic       x_a, busy_a, done_a;
    logic [3:0] ones_a;

    logic       start_b, abort_b;
    logic [2:0] mode_b;
    logic [0:0] vec_b;
    logic       x_b, busy_b, done_b;
    logic [1:0] ones_b;

    logic       start_c, abort_c;
    logic [2:0] mode_c;
    logic [7:0] vec_c;
    logic       x_c, busy_c, done_c;
    logic [8:0] ones_c;

    int n_chk;
    int n_err;

    gate_sweep #(.N(3), .DWELL(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .mode(mode_a), .vec_out(vec_a), .x_out(x_a), .busy(busy_a),
        .done(done_a), .ones_count(ones_a)
    );

    gate_sweep #(.N(1), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .mode(mode_b), .vec_out(vec_b), .x_out(x_b), .busy(busy_b),
        .done(done_b), .ones_count(ones_b)
    );

    gate_sweep #(.N(8), .DWELL(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c),
        .mode(mode_c), .vec_out(vec_c), .x_out(x_c), .busy(busy_c),
        .done(done_c), .ones_count(ones_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on instance A; poke>=0 changes mode and pulses start
    // at that cycle.
    task automatic run_a(input logic [2:0] m, input int poke,
                         output int cyc, output int ones, output int xs);
        mode_a  = m;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        cyc = 0;
        xs  = 0;
        while (!done_a && cyc < 1000) begin
            xs += int'(x_a);
            if (cyc == poke) begin
                mode_a  = 3'd1;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            tick();
            cyc++;
        end
        start_a = 1'b0;
        ones = int'(ones_a);
        tick();
    endtask

    initial begin
        int cyc, ones, xs;
        int exp_m [8] = '{1, 7, 7, 1, 4, 4, 0, 0};
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        start_a = 0; abort_a = 0; mode_a = 0;
        start_b = 0; abort_b = 0; mode_b = 0;
        start_c = 0; abort_c = 0; mode_c = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec", 32'(vec_a), 0);
        chk("rst_x", 32'(x_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_ones", 32'(ones_a), 0);
        rst = 1'b0;
        tick();

        // NOR trace
        mode_a  = 3'd3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("nor_vec", 32'(vec_a), 32'(c / 2));
            chk("nor_x", 32'(x_a), (c / 2 == 0) ? 1 : 0);
            chk("nor_busy", 32'(busy_a), 1);
            chk("nor_done", 32'(done_a), 0);
            tick();
        end
        chk("nor_done_hi", 32'(done_a), 1);
        chk("nor_ones", 32'(ones_a), 1);
        chk("nor_done_busy", 32'(busy_a), 0);
        chk("nor_done_vec", 32'(vec_a), 0);
        chk("nor_done_x", 32'(x_a), 0);
        tick();
        chk("nor_done_lo", 32'(done_a), 0);
        chk("nor_hold", 32'(ones_a), 1);

        for (int m = 0; m < 8; m++) begin
            run_a(3'(m), -1, cyc, ones, xs);
            chk("mode_len", 32'(cyc), 16);
            chk("mode_ones", 32'(ones), 32'(exp_m[m]));
            if (m >= 6) chk("mode_rsv_x", 32'(xs), 0);
        end

        run_a(3'd0, 5, cyc, ones, xs);
        chk("latch_len", 32'(cyc), 16);
        chk("latch_ones", 32'(ones), 1);

        // Abort during second dwell cycle of vector 3
        mode_a  = 3'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        chk("ab_pre_vec", 32'(vec_a), 3);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("ab_busy", 32'(busy_a), 0);
        chk("ab_done", 32'(done_a), 0);
        chk("ab_ones", 32'(ones_a), 2);
        chk("ab_vec", 32'(vec_a), 0);
        tick();
        chk("ab_done2", 32'(done_a), 0);
        chk("ab_hold", 32'(ones_a), 2);

        // Async reset mid-run
        mode_a  = 3'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        chk("ar_pre_ones", 32'(ones_a), 1);
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy_a), 0);
        chk("ar_vec", 32'(vec_a), 0);
        chk("ar_x", 32'(x_a), 0);
        chk("ar_ones", 32'(ones_a), 0);
        chk("ar_done", 32'(done_a), 0);
        #2;
        rst = 1'b0;
        tick();
        run_a(3'd1, -1, cyc, ones, xs);
        chk("ar_len", 32'(cyc), 16);
        chk("ar_sweep", 32'(ones), 7);

        // N=1, DWELL=1, XOR
        mode_b  = 3'd4;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("n1_len", 32'(cyc), 2);
        chk("n1_ones", 32'(ones_b), 1);

        // N=8, DWELL=1, AND
        mode_c  = 3'd0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        cyc = 0;
        while (!done_c && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("n8_len", 32'(cyc), 256);
        chk("n8_ones", 32'(ones_c), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
